pipe_stage_buf: RTL

- Parametrised pipeline stage register, the successor to the fixed five-word write-back flop.
- Carries NCH data words plus a register-index tag between pipeline stages.
- Adds a valid/ready handshake, a 2-entry skid buffer (full throughput with registered in_ready), a flush, and a saturating stall counter.
- Drops in between any two stages of the pipelined core (e.g. MEM→WB).

---
 rtl/pipe_stage_buf.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/pipe_stage_buf.sv
// Pipeline stage register with a 2-entry skid buffer, valid/ready handshake,
// flush and a saturating stall counter. All outputs come straight from flops.
module pipe_stage_buf #(
  parameter int DATA_W = 32,
  parameter int NCH    = 5,
  parameter int TAG_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NCH*DATA_W-1:0] in_data,
  input  logic [TAG_W-1:0]      in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [NCH*DATA_W-1:0] out_data,
  output logic [TAG_W-1:0]      out_tag,
  output logic [1:0]            occupancy,
  output logic [CNT_W-1:0]      stall_cnt
);

  localparam int W = NCH * DATA_W;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL1 = 2'd1,
    FULL2 = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [W-1:0]       head_data_q, head_data_d;
  logic [TAG_W-1:0]   head_tag_q, head_tag_d;
  logic [W-1:0]       skid_data_q, skid_data_d;
  logic [TAG_W-1:0]   skid_tag_q, skid_tag_d;
  logic               out_valid_q, out_valid_d;
  logic               in_ready_q, in_ready_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic               accept_s;
  logic               consume_s;

  assign accept_s  = in_valid & in_ready_q;
  assign consume_s = out_valid_q & out_ready;

  // Next-state, entry movement and stall counter
  always_comb begin
    state_d     = state_q;
    head_data_d = head_data_q;
    head_tag_d  = head_tag_q;
    skid_data_d = skid_data_q;
    skid_tag_d  = skid_tag_q;

    if (flush) begin
      state_d     = EMPTY;
      head_data_d = '0;
      head_tag_d  = '0;
      skid_data_d = '0;
      skid_tag_d  = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept_s) begin
            state_d     = FULL1;
            head_data_d = in_data;
            head_tag_d  = in_tag;
          end else begin
            state_d = EMPTY;
          end
        end
        FULL1: begin
          if (accept_s && consume_s) begin
            head_data_d = in_data;
            head_tag_d  = in_tag;
          end else if (accept_s) begin
            state_d     = FULL2;
            skid_data_d = in_data;
            skid_tag_d  = in_tag;
          end else if (consume_s) begin
            // head keeps its last value so out_data holds after draining
            state_d = EMPTY;
          end else begin
            state_d = FULL1;
          end
        end
        FULL2: begin
          if (consume_s) begin
            state_d     = FULL1;
            head_data_d = skid_data_q;
            head_tag_d  = skid_tag_q;
          end else begin
            state_d = FULL2;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end

    out_valid_d = (state_d != EMPTY);
    in_ready_d  = (state_d != FULL2);

    if (out_valid_q && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= EMPTY;
      head_data_q <= '0;
      head_tag_q  <= '0;
      skid_data_q <= '0;
      skid_tag_q  <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      head_data_q <= head_data_d;
      head_tag_q  <= head_tag_d;
      skid_data_q <= skid_data_d;
      skid_tag_q  <= skid_tag_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = head_data_q;
  assign out_tag   = head_tag_q;
  assign occupancy = state_q;
  assign stall_cnt = stall_cnt_q;

endmodule
